zstr_arb: RTL and testbench

Round-robin arbiter that shares one z stream sink between N z stream sources. Each source presents `vld`/`bus`/`rdy` handshakes. The arbiter grants one source at a time and forwards its transfers through a single registered output stage. It sits between multiple `zstr` sources (RTL masters or bench models) and one downstream `zstr` consumer.

---
 rtl/zstr_pkg.sv | 38 +++
 rtl/zstr_rr_sel.sv | 34 +++
 rtl/zstr_arb.sv | 106 ++++++++++
 tb/tb_zstr_arb.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zstr_pkg.sv
// Shared z-stream definitions: arbiter state encoding and a round-robin helper
// for blocks that prefer a function over instantiating zstr_rr_sel.
package zstr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } zstr_arb_state_t;

    localparam int unsigned RR_MAX_N = 32;
    localparam int unsigned RR_IW    = 5;

    typedef struct packed {
        logic             found;
        logic [RR_IW-1:0] idx;
    } rr_res_t;

    // Circular search of vld starting at ptr+1; only the low n requesters take part.
    function automatic rr_res_t rr_next(
        input logic [RR_MAX_N-1:0] vld,
        input logic [RR_IW-1:0]    ptr,
        input int unsigned         n = RR_MAX_N
    );
        rr_res_t     r;
        int unsigned cand;
        r = '0;
        for (int unsigned k = 1; k <= RR_MAX_N; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= n) cand = cand - n;
            if (k <= n && !r.found && vld[cand[RR_IW-1:0]]) begin
                r.found = 1'b1;
                r.idx   = cand[RR_IW-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/zstr_rr_sel.sv
// Combinational round-robin selector: first set bit of vld after ptr, wrapping
// at N. The current ptr is considered last, so it wins only when alone.
module zstr_rr_sel
    import zstr_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  vld,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);

    localparam logic [IW:0] N_W = N[IW:0];

    logic [IW:0] cand;

    // One guard bit above IW lets ptr+k exceed N before the explicit wrap.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = {1'b0, ptr} + k[IW:0];
            if (cand >= N_W) cand = cand - N_W;
            if (!found && vld[cand[IW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/zstr_arb.sv
// Round-robin arbiter sharing one z-stream sink between N sources through a
// single registered output slot. ZSTR_ARB_PKT_EN locks the grant until s_lst.
module zstr_arb
    import zstr_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned BW = 1,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    s_vld,
    input  logic [N*BW-1:0] s_bus,
    output logic [N-1:0]    s_rdy,
`ifdef ZSTR_ARB_PKT_EN
    input  logic [N-1:0]    s_lst,
`endif
    output logic            m_vld,
    output logic [BW-1:0]   m_bus,
    input  logic            m_rdy,
    output logic            gnt_vld,
    output logic [IW-1:0]   gnt
);

    localparam logic [IW-1:0] PTR_RST = IW'(N - 1);

    zstr_arb_state_t state_q;
    logic [IW-1:0]   gnt_q;
    logic [IW-1:0]   ptr_q;
    logic            m_vld_q;
    logic [BW-1:0]   m_bus_q;

    logic            slot_free;
    logic            xfer;
    logic            eog;
    logic            sel_found;
    logic [IW-1:0]   sel_idx;

    zstr_rr_sel #(
        .N  (N),
        .IW (IW)
    ) u_sel (
        .vld   (s_vld),
        .ptr   (ptr_q),
        .idx   (sel_idx),
        .found (sel_found)
    );

    assign gnt_vld   = (state_q == GRANT);
    assign gnt       = gnt_q;
    assign m_vld     = m_vld_q;
    assign m_bus     = m_bus_q;
    assign slot_free = ~m_vld_q | m_rdy;
    assign xfer      = gnt_vld & slot_free & s_vld[gnt_q];

`ifdef ZSTR_ARB_PKT_EN
    assign eog = xfer & s_lst[gnt_q];
`else
    assign eog = xfer;
`endif

    always_comb begin
        s_rdy = '0;
        if (gnt_vld && slot_free) s_rdy[gnt_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= PTR_RST;
            m_vld_q <= 1'b0;
            m_bus_q <= '0;
        end else begin
            // A load in the same cycle as an output transfer keeps the slot full.
            if (xfer) begin
                m_vld_q <= 1'b1;
                m_bus_q <= s_bus[gnt_q*BW +: BW];
            end else if (m_rdy) begin
                m_vld_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (sel_found) begin
                        state_q <= GRANT;
                        gnt_q   <= sel_idx;
                        ptr_q   <= sel_idx;
                    end
                end
                GRANT: begin
                    if (eog) begin
                        if (sel_found) begin
                            gnt_q <= sel_idx;
                            ptr_q <= sel_idx;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zstr_arb.sv
// Bench for zstr_arb (N=4, BW=8): spec vector table, directed corner sequences
// and a randomized run checked every cycle against a behavioural model.
module tb_zstr_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned BW = 8;
    localparam int unsigned IW = 2;
`ifdef ZSTR_ARB_PKT_EN
    localparam bit PKT = 1'b1;
`else
    localparam bit PKT = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [N-1:0]    s_vld;
    logic [N*BW-1:0] s_bus;
    logic [N-1:0]    s_rdy;
    logic [N-1:0]    s_lst;
    logic            m_vld;
    logic [BW-1:0]   m_bus;
    logic            m_rdy;
    logic            gnt_vld;
    logic [IW-1:0]   gnt;

    zstr_arb #(
        .N  (N),
        .BW (BW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_vld   (s_vld),
        .s_bus   (s_bus),
        .s_rdy   (s_rdy),
`ifdef ZSTR_ARB_PKT_EN
        .s_lst   (s_lst),
`endif
        .m_vld   (m_vld),
        .m_bus   (m_bus),
        .m_rdy   (m_rdy),
        .gnt_vld (gnt_vld),
        .gnt     (gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: who holds the grant, the last winner, and the slot contents.
    logic          mg_v;
    int            mg;
    int            mptr;
    logic          ms_v;
    logic [BW-1:0] ms_b;
    logic          last_acc;
    int            last_idx;

    typedef struct {
        logic            r;
        logic [N-1:0]    v;
        logic [N*BW-1:0] b;
        logic            mr;
        logic            egv;
        logic [IW-1:0]   eg;
        logic [N-1:0]    erdy;
        logic            emv;
        logic [BW-1:0]   emb;
    } vec_t;

    vec_t tbl [11];

    logic [N-1:0]    sv;
    logic [N-1:0]    sl;
    logic [N*BW-1:0] sb;
    logic [N*BW-1:0] rb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int next_req(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= int'(N); k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [N*BW-1:0] put(input logic [N*BW-1:0] b, input int i, input logic [BW-1:0] d);
        logic [N*BW-1:0] t;
        t = b;
        t[i*BW +: BW] = d;
        return t;
    endfunction

    task automatic cycle(input logic r, input logic [N-1:0] v, input logic [N*BW-1:0] b,
                         input logic mr, input logic [N-1:0] l);
        logic        free;
        logic        acc;
        logic [31:0] erdy;
        int          nx;
        @(negedge clk);
        rst   = r;
        s_vld = v;
        s_bus = b;
        m_rdy = mr;
        s_lst = l;
        #1;
        free = !ms_v || mr;
        erdy = (mg_v && free) ? (32'd1 << mg) : 32'd0;
        if (chk_en) begin
            chk("model gnt_vld", 32'(gnt_vld), 32'(mg_v));
            chk("model gnt", 32'(gnt), mg);
            chk("model s_rdy", 32'(s_rdy), erdy);
            chk("model m_vld", 32'(m_vld), 32'(ms_v));
            chk("model m_bus", 32'(m_bus), 32'(ms_b));
            chk("model ptr", 32'(dut.ptr_q), mptr);
        end
        acc      = r && mg_v && free && v[mg];
        last_acc = acc;
        last_idx = mg;
        if (!r) begin
            mg_v = 1'b0; mg = 0; mptr = N - 1; ms_v = 1'b0; ms_b = '0;
        end else begin
            if (acc) begin
                ms_v = 1'b1;
                ms_b = b[mg*BW +: BW];
            end else if (mr) begin
                ms_v = 1'b0;
            end
            if (!mg_v) begin
                nx = next_req(v, mptr);
                if (nx >= 0) begin mg_v = 1'b1; mg = nx; mptr = nx; end
            end else if (acc && (!PKT || l[mg])) begin
                nx = next_req(v, mptr);
                if (nx >= 0) begin mg = nx; mptr = nx; end
                else mg_v = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        cycle(1'b0, '0, '0, 1'b1, '0);
    endtask

    initial begin
        rst = 1'b0; s_vld = '0; s_bus = '0; m_rdy = 1'b1; s_lst = '0;
        mg_v = 1'b0; mg = 0; mptr = N - 1; ms_v = 1'b0; ms_b = '0;
        last_acc = 1'b0; last_idx = 0;

        tbl[0]  = '{1'b0, 4'h0, 32'h0000_0000, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 4'h1, 32'h0000_00A5, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 4'h1, 32'h0000_00A5, 1'b1, 1'b1, 2'd0, 4'h1, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 4'h0, 32'h0000_0000, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1, 8'hA5};
        tbl[4]  = '{1'b0, 4'h0, 32'h0000_0000, 1'b1, 1'b1, 2'd0, 4'h1, 1'b0, 8'hA5};
        tbl[5]  = '{1'b1, 4'h8, 32'h3000_0000, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00};
        tbl[6]  = '{1'b1, 4'h8, 32'h3000_0000, 1'b1, 1'b1, 2'd3, 4'h8, 1'b0, 8'h00};
        tbl[7]  = '{1'b1, 4'h8, 32'h3100_0000, 1'b1, 1'b1, 2'd3, 4'h8, 1'b1, 8'h30};
        tbl[8]  = '{1'b1, 4'h8, 32'h3200_0000, 1'b1, 1'b1, 2'd3, 4'h8, 1'b1, 8'h31};
        tbl[9]  = '{1'b1, 4'h8, 32'h3300_0000, 1'b1, 1'b1, 2'd3, 4'h8, 1'b1, 8'h32};
        tbl[10] = '{1'b1, 4'h0, 32'h0000_0000, 1'b1, 1'b1, 2'd3, 4'h8, 1'b1, 8'h33};

        // Power-up cycle: outputs are undefined until the first reset edge.
        do_reset();
        chk_en = 1'b1;

        for (int k = 0; k < 11; k++) begin
            cycle(tbl[k].r, tbl[k].v, tbl[k].b, tbl[k].mr, '0);
            chk($sformatf("vec%0d gnt_vld", k), 32'(gnt_vld), 32'(tbl[k].egv));
            chk($sformatf("vec%0d gnt", k), 32'(gnt), 32'(tbl[k].eg));
            chk($sformatf("vec%0d s_rdy", k), 32'(s_rdy), 32'(tbl[k].erdy));
            chk($sformatf("vec%0d m_vld", k), 32'(m_vld), 32'(tbl[k].emv));
            chk($sformatf("vec%0d m_bus", k), 32'(m_bus), 32'(tbl[k].emb));
        end

        // Round-robin fairness with all sources requesting.
        do_reset();
        rb = 32'hC3C2_C1C0;
        cycle(1'b1, 4'hF, rb, 1'b1, '0);
        chk("rr first gnt_vld", 32'(gnt_vld), 0);
        for (int c = 1; c <= 8; c++) begin
            cycle(1'b1, 4'hF, rb, 1'b1, '0);
            chk("rr gnt", 32'(gnt), (c - 1) % 4);
            chk("rr s_rdy", 32'(s_rdy), 1 << ((c - 1) % 4));
            if (c >= 2) begin
                chk("rr m_vld", 32'(m_vld), 1);
                chk("rr m_bus", 32'(m_bus), 32'hC0 + (c - 2) % 4);
            end
        end

        // Backpressure: everything holds, then the stream resumes in order.
        for (int c = 0; c < 5; c++) begin
            cycle(1'b1, 4'hF, rb, 1'b0, '0);
            chk("bp s_rdy", 32'(s_rdy), 0);
            chk("bp gnt", 32'(gnt), 0);
            chk("bp m_vld", 32'(m_vld), 1);
            chk("bp m_bus", 32'(m_bus), 32'hC3);
            chk("bp ptr", 32'(dut.ptr_q), 0);
        end
        cycle(1'b1, 4'hF, rb, 1'b1, '0);
        chk("bp resume s_rdy", 32'(s_rdy), 1);
        cycle(1'b1, 4'hF, rb, 1'b1, '0);
        chk("bp resume gnt", 32'(gnt), 1);
        chk("bp resume m_bus", 32'(m_bus), 32'hC0);

`ifdef ZSTR_ARB_PKT_EN
        // Packet lock: source 1 sends three beats while source 2 waits.
        do_reset();
        cycle(1'b1, 4'h6, 32'h0022_1100, 1'b1, 4'h0);
        cycle(1'b1, 4'h6, 32'h0022_1100, 1'b1, 4'h0);
        chk("pkt beat1 gnt", 32'(gnt), 1);
        cycle(1'b1, 4'h6, 32'h0022_1200, 1'b1, 4'h0);
        chk("pkt beat2 gnt", 32'(gnt), 1);
        chk("pkt beat2 m_bus", 32'(m_bus), 32'h11);
        cycle(1'b1, 4'h6, 32'h0022_1300, 1'b1, 4'h2);
        chk("pkt beat3 gnt", 32'(gnt), 1);
        chk("pkt beat3 m_bus", 32'(m_bus), 32'h12);
        cycle(1'b1, 4'h4, 32'h0022_0000, 1'b1, 4'h4);
        chk("pkt switch gnt", 32'(gnt), 2);
        chk("pkt switch m_bus", 32'(m_bus), 32'h13);
        cycle(1'b1, 4'h0, 32'h0000_0000, 1'b1, 4'h0);
        chk("pkt src2 m_bus", 32'(m_bus), 32'h22);
`endif

        // Reset during beat 2, then a fresh grant to source 0.
        do_reset();
        cycle(1'b1, 4'h1, 32'h0000_00A0, 1'b1, '0);
        cycle(1'b1, 4'h1, 32'h0000_00A0, 1'b1, '0);
        cycle(1'b0, 4'h1, 32'h0000_00A1, 1'b1, '0);
        chk("midrst pre m_vld", 32'(m_vld), 1);
        cycle(1'b1, 4'h3, 32'h0000_B1A1, 1'b1, '0);
        chk("midrst m_vld", 32'(m_vld), 0);
        chk("midrst gnt_vld", 32'(gnt_vld), 0);
        chk("midrst ptr", 32'(dut.ptr_q), N - 1);
        cycle(1'b1, 4'h3, 32'h0000_B1A1, 1'b1, '0);
        chk("midrst regrant gnt_vld", 32'(gnt_vld), 1);
        chk("midrst regrant gnt", 32'(gnt), 0);

        // Randomized traffic with well-behaved sources and occasional reset.
        sv = '0; sl = '0; sb = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (!sv[i] && $urandom_range(2) == 0) begin
                    sv[i] = 1'b1;
                    sb    = put(sb, i, 8'($urandom));
                    sl[i] = 1'($urandom);
                end
            end
            cycle($urandom_range(299) != 0, sv, sb, $urandom_range(9) < 7, sl);
            if (last_acc) begin
                if ($urandom_range(1) == 1) begin
                    sb = put(sb, last_idx, 8'($urandom));
                    sl[last_idx] = 1'($urandom);
                end else begin
                    sv[last_idx] = 1'b0;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
